addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter LAT, default 1, range 1..15: number of adder-settle cycles between operand capture and result capture.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 is granted; transfer occurs when valid and ready are both high.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 op select: 1 computes A-B, 0 computes A+B.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions and widths as requester 0, for requester 1.
REQ-009 rsp_valid  output  1  result is held and valid.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_ans  output  32  the sum or difference.
REQ-013 rsp_cout, rsp_v  output  1 each  carry-out and signed-overflow flag, carry(31) XOR carry(32).

Function
REQ-014 FSM states: IDLE, EXEC, RESP; exactly one shared add/sub datapath instance.
- IDLE: if any reqN_valid is high, assert ready combinationally to exactly one winner.
- IDLE: on the accepting edge, register A, B, SUB and id, load the settle counter with LAT-1, then go to EXEC.
- EXEC: decrement the counter each cycle.
- EXEC at counter 0: register ans, cout and V into the rsp_* outputs, then go to RESP.
- RESP: hold rsp_valid=1; when rsp_valid and rsp_ready are both high, go to IDLE.
REQ-015 rsp_valid shall rise after the LAT-th rising edge following the accepting edge.
- Minimum issue interval is LAT+2 cycles.
REQ-016 req0_ready and req1_ready shall be 0 in EXEC and RESP, and shall never both be 1.
REQ-017 rsp_* shall remain stable while rsp_valid=1 and rsp_ready=0, for any duration.
REQ-018 Operand inputs are sampled only on the accepting edge.
- Input changes after that edge shall not affect the in-flight result.
REQ-019 Arithmetic is 32-bit two's-complement and wraps modulo 2^32.
- SUB=1 inverts B and forces carry-in to 1.
- cout is the raw carry, so A-A yields ans=0, cout=1.
REQ-020 A reqN_valid that deasserts before it is granted shall be dropped without side effects.
REQ-021 With both requesters valid in IDLE, the winner is set by the arbitration policy (REQ-026/REQ-027).
- rsp_ready arriving in the same cycle as new requests shall not create a grant until the next IDLE cycle.

Reset
REQ-022 rst=1 at any clock edge shall force state IDLE and counter 0.
- Same reset applies to every output register: rsp_valid=0, rsp_id=0, rsp_ans=0, rsp_cout=0, rsp_v=0.
- The round-robin pointer shall reset to favour requester 0.
REQ-023 Reset during EXEC or RESP shall discard the in-flight operation.
- No response is produced for it after reset releases.
REQ-024 While rst=1, req0_ready and req1_ready shall be 0.

Configuration
REQ-025 Macro ADDSUB_ARB_RR_EN selects the arbitration policy.
REQ-026 With ADDSUB_ARB_RR_EN defined, arbitration is round-robin.
- On a conflict, the requester not granted most recently wins.
- The pointer updates only on an accepting edge.
REQ-027 Without ADDSUB_ARB_RR_EN, arbitration is fixed priority: requester 0 always wins conflicts.
- No pointer register is built.

Structure
REQ-028 A shared package shall hold:
- the FSM state typedef (2-bit encoding);
- the localparam DATA_W=32;
- the localparam NUM_REQ=2.
REQ-029 The block shall instantiate the team's existing 32-bit ripple add/sub module as its one sub-module.
- No other arithmetic logic is allowed.

Verification
REQ-030 LAT=1; req0 A=00000021, B=00000022, SUB=0 -> rsp_ans=00000043, cout=0, v=0, id=0; rsp_valid high one edge after the accept.
REQ-031 req1 A=7FFFFFFF, B=00000001, SUB=0 -> rsp_ans=80000000, cout=0, v=1, id=1; then A=80000000, B=00000001, SUB=1 -> 7FFFFFFF, cout=1, v=1.
REQ-032 Both requesters valid continuously, rsp_ready=1, RR_EN defined -> grants alternate 0,1,0,1; without RR_EN -> all grants go to 0.
REQ-033 LAT=3; req0 A=336FB7E5, B=336FB7E5, SUB=1, with rsp_ready held low for 5 cycles -> rsp_valid asserts 3 edges after the accept; ans=00000000, cout=1 held stable; no grants until the handshake completes.
REQ-034 rst pulsed during EXEC -> next cycle rsp_valid=0, all rsp_* are 0, state IDLE; the following conflict is granted to requester 0.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// Shared types and sizes for the two-requester add/sub arbiter.
package addsub_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_arbiter_ripple.sv
// 32-bit ripple-carry adder/subtractor: sub=1 computes a-b via ~b and carry-in 1.
module addsub_arbiter_ripple
    import addsub_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] ans,
    output logic              cout,
    output logic              v
);

    logic [DATA_W:0]   carry;
    logic [DATA_W-1:0] b_eff;

    assign carry[0] = sub;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign b_eff[gi]     = b[gi] ^ sub;
            assign ans[gi]       = a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
        end
    endgenerate

    // cout is the raw carry; signed overflow compares the carries into and out of the MSB
    assign cout = carry[DATA_W];
    assign v    = carry[DATA_W] ^ carry[DATA_W-1];

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one add/sub datapath with LAT settle cycles.
// Define ADDSUB_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_ans,
    output logic              rsp_cout,
    output logic              rsp_v
);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [DATA_W-1:0]   a_reg, b_reg;
    logic                sub_reg, id_reg;
    logic                rsp_valid_reg, rsp_id_reg, rsp_cout_reg, rsp_v_reg;
    logic [DATA_W-1:0]   rsp_ans_reg;

    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  req_sub;
    logic [DATA_W-1:0]   req_a [NUM_REQ];
    logic [DATA_W-1:0]   req_b [NUM_REQ];
    logic [NUM_REQ-1:0]  grant;
    logic                win_id;
    logic                accept;
    logic                load_op;
    logic                capture;

    logic [DATA_W-1:0]   dp_ans;
    logic                dp_cout, dp_v;

    assign req_valid = {req1_valid, req0_valid};
    assign req_sub   = {req1_sub, req0_sub};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;

`ifdef ADDSUB_ARB_RR_EN
    // Requester favoured on the next conflict; flips away from each accepted winner.
    logic ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~win_id;
        end
    end

    assign win_id = (&req_valid) ? ptr_reg : req_valid[1];
`else
    assign win_id = ~req_valid[0];
`endif

    // Ready is only offered from IDLE, so an accept is exactly a grant
    assign accept = (state_reg == ST_IDLE) && !rst && (|req_valid);

    always_comb begin
        grant = '0;
        if (accept) begin
            grant[win_id] = 1'b1;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load_op    = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    load_op    = 1'b1;
                    cnt_next   = 4'(LAT - 1);
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_valid_reg && rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Operands are frozen at the accepting edge so later input changes cannot leak in
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sub_reg <= 1'b0;
            id_reg  <= 1'b0;
        end else if (load_op) begin
            a_reg   <= req_a[win_id];
            b_reg   <= req_b[win_id];
            sub_reg <= req_sub[win_id];
            id_reg  <= win_id;
        end
    end

    addsub_arbiter_ripple u_ripple (
        .a    (a_reg),
        .b    (b_reg),
        .sub  (sub_reg),
        .ans  (dp_ans),
        .cout (dp_cout),
        .v    (dp_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_ans_reg   <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_v_reg     <= 1'b0;
        end else if (capture) begin
            rsp_valid_reg <= 1'b1;
            rsp_id_reg    <= id_reg;
            rsp_ans_reg   <= dp_ans;
            rsp_cout_reg  <= dp_cout;
            rsp_v_reg     <= dp_v;
        end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_ans   = rsp_ans_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_v     = rsp_v_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed-vector bench for addsub_arbiter: one LAT=1 instance and one LAT=3 instance.
module tb_addsub_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // LAT=1 instance signals
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_sub = 1'b0, req1_sub = 1'b0;
    logic        rsp_valid, rsp_id, rsp_cout, rsp_v;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_ans;

    // LAT=3 instance signals
    logic        rst_l3 = 1'b1;
    logic        req0_valid_l3 = 1'b0, req1_valid_l3 = 1'b0;
    logic        req0_ready_l3, req1_ready_l3;
    logic [31:0] req0_a_l3 = '0, req0_b_l3 = '0, req1_a_l3 = '0, req1_b_l3 = '0;
    logic        req0_sub_l3 = 1'b0, req1_sub_l3 = 1'b0;
    logic        rsp_valid_l3, rsp_id_l3, rsp_cout_l3, rsp_v_l3;
    logic        rsp_ready_l3 = 1'b0;
    logic [31:0] rsp_ans_l3;

    addsub_arbiter #(.LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ans(rsp_ans),
        .rsp_cout(rsp_cout), .rsp_v(rsp_v)
    );

    addsub_arbiter #(.LAT(3)) dut_l3 (
        .clk(clk), .rst(rst_l3),
        .req0_valid(req0_valid_l3), .req0_ready(req0_ready_l3), .req0_a(req0_a_l3), .req0_b(req0_b_l3), .req0_sub(req0_sub_l3),
        .req1_valid(req1_valid_l3), .req1_ready(req1_ready_l3), .req1_a(req1_a_l3), .req1_b(req1_b_l3), .req1_sub(req1_sub_l3),
        .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready_l3), .rsp_id(rsp_id_l3), .rsp_ans(rsp_ans_l3),
        .rsp_cout(rsp_cout_l3), .rsp_v(rsp_v_l3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    // One complete LAT=1 transaction from a single requester, with rsp_ready held high
    task automatic run_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_ans, input logic exp_cout, input logic exp_v);
        @(negedge clk);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end
        rsp_ready = 1'b1;
        #1 check({tag, "_grant"}, 32'({req1_ready, req0_ready}), (id == 1'b0) ? 32'd1 : 32'd2);
        @(negedge clk);
        // Scramble operands after the accepting edge; the result must not change
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req1_a = ~a; req0_b = a; req1_b = a;
        req0_sub = ~sub; req1_sub = ~sub;
        #1 check({tag, "_exec"}, 32'({rsp_valid, req1_ready, req0_ready}), 32'd0);
        @(negedge clk);
        check({tag, "_ans"}, rsp_ans, exp_ans);
        check({tag, "_flags"}, 32'({rsp_valid, rsp_cout, rsp_v, rsp_id}), 32'({1'b1, exp_cout, exp_v, id}));
        @(negedge clk);
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         got_n;
        logic [3:0] seq;
        logic [3:0] exp_seq;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_v}), 32'd0);
        check("rst_ans", rsp_ans, 32'd0);
        check("rst_l3_rsp", 32'({rsp_valid_l3, rsp_id_l3, rsp_cout_l3, rsp_v_l3}), 32'd0);
        rst = 1'b0;
        rst_l3 = 1'b0;

        // Basic arithmetic and overflow cases
        run_op("add_small", 1'b0, 32'h00000021, 32'h00000022, 1'b0, 32'h00000043, 1'b0, 1'b0);
        run_op("add_ovf",   1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("sub_ovf",   1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("sub_zero",  1'b0, 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0);

        // Continuous conflict: record the first four grants
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_sub = 1'b1;
        rsp_ready = 1'b1;
        got_n = 0;
        seq = 4'b0000;
        for (int cyc = 0; cyc < 40 && got_n < 4; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                check("grant_excl", 32'(req0_ready & req1_ready), 32'd0);
                seq[got_n] = req1_ready;
                got_n++;
            end
            @(negedge clk);
        end
        check("grant_cnt", 32'(got_n), 32'd4);
`ifdef ADDSUB_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        check("grant_seq", 32'(seq), 32'(exp_seq));
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("grant_drain", 32'(rsp_valid), 32'd0);

        // Reset during EXEC discards the operation and restores the arbitration pointer
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_sub = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_exec_rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_v}), 32'd0);
        check("rst_exec_ans", rsp_ans, 32'd0);
        @(negedge clk);
        #1 check("rst_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
        rst = 1'b0;
        req1_valid = 1'b1;
        #1 check("rst_conflict", 32'({req1_ready, req0_ready}), 32'd1);
        check("rst_no_rsp", 32'(rsp_valid), 32'd0);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("drop_idle", 32'({rsp_valid, req1_ready, req0_ready}), 32'd0);

        // LAT=3 with back-pressure; requester 1 waits and must not be granted early
        @(negedge clk);
        req0_valid_l3 = 1'b1; req0_a_l3 = 32'h336FB7E5; req0_b_l3 = 32'h336FB7E5; req0_sub_l3 = 1'b1;
        rsp_ready_l3 = 1'b0;
        #1 check("l3_grant", 32'({req1_ready_l3, req0_ready_l3}), 32'd1);
        @(negedge clk);
        req0_valid_l3 = 1'b0; req0_a_l3 = 32'hFFFFFFFF; req0_sub_l3 = 1'b0;
        req1_valid_l3 = 1'b1; req1_a_l3 = 32'd7; req1_b_l3 = 32'd8; req1_sub_l3 = 1'b0;
        #1 check("l3_edge0", 32'({rsp_valid_l3, req1_ready_l3, req0_ready_l3}), 32'd0);
        @(negedge clk);
        #1 check("l3_edge1", 32'({rsp_valid_l3, req1_ready_l3, req0_ready_l3}), 32'd0);
        @(negedge clk);
        #1 check("l3_edge2", 32'({rsp_valid_l3, req1_ready_l3, req0_ready_l3}), 32'd0);
        @(negedge clk);
        check("l3_ans", rsp_ans_l3, 32'd0);
        check("l3_flags", 32'({rsp_valid_l3, rsp_cout_l3, rsp_v_l3, rsp_id_l3}), 32'b1100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("l3_hold_ans", rsp_ans_l3, 32'd0);
            check("l3_hold_flags", 32'({rsp_valid_l3, rsp_cout_l3, rsp_v_l3, rsp_id_l3, req1_ready_l3, req0_ready_l3}),
                  32'b110000);
        end
        rsp_ready_l3 = 1'b1;
        @(negedge clk);
        #1 check("l3_release", 32'({rsp_valid_l3, req1_ready_l3, req0_ready_l3}), 32'b010);
        req1_valid_l3 = 1'b0;
        rsp_ready_l3 = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
